// File: rtl/frame_seq_pkg.sv
// Shared types and constants for the frame FIFO sequencer.
//   state_t       : sequencer FSM states
//   HDR_*         : header word layout {magic, frame_count[15:0], timestamp}
package frame_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HUNT,
    S_HEADER,
    S_DATA,
    S_DROP
  } state_t;

  localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hA5C3;
  localparam int          HDR_MAGIC_LSB     = 48;
  localparam int          HDR_FC_LSB        = 32;
  localparam int          HDR_TS_LSB        = 0;

endpackage

// File: rtl/frame_fifo_sequencer_sat_counter.sv
// Saturating up-counter.
//   clk, rstn : clock, async active-low reset
//   inc       : increment request (ignored once count is all-ones)
//   count     : current value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                    count <= '0;
    else if (inc && count != '1)  count <= count + 1'b1;
  end

endmodule

// File: rtl/frame_fifo_sequencer.sv
// Frames source sample words into packets for the packer FIFO:
// one header word followed by cfg_frame_words data words. A frame is admitted
// only if the packer FIFO can hold the whole packet plus a margin; otherwise
// the whole frame is consumed and dropped.
//   clk, rstn            : clock, async active-low reset
//   enable               : run control (frames in flight always complete)
//   cfg_frame_words/mask : frame length (0 -> 1) and last-word channel mask
//   src_*                : source stream, transfers on src_valid && src_ready
//   fifo_full/count      : packer FIFO status
//   fifo_write_*, fifo_channel_mask, fifo_packet_end_flag : registered packer write
//   frame_count, drop_count, sync_err_count, overflow_sticky, busy : status
module frame_fifo_sequencer
  import frame_seq_pkg::*;
#(
  parameter int          FIFO_DEPTH      = 256,
  parameter int          MAX_FRAME_WORDS = 255,
  parameter int          ADMIT_MARGIN    = 2,
  parameter logic [15:0] HEADER_MAGIC    = HDR_MAGIC_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [7:0]  cfg_frame_words,
  input  logic [3:0]  cfg_last_mask,
  input  logic        src_valid,
  input  logic        src_first,
  input  logic [63:0] src_data,
  output logic        src_ready,
  input  logic        fifo_full,
  input  logic [8:0]  fifo_count,
  output logic        fifo_write_en,
  output logic [63:0] fifo_write_data,
  output logic [3:0]  fifo_channel_mask,
  output logic        fifo_packet_end_flag,
  output logic [31:0] frame_count,
  output logic [15:0] drop_count,
  output logic [15:0] sync_err_count,
  output logic        overflow_sticky,
  output logic        busy
);

  state_t      r_state, w_next;
  logic [31:0] r_ts;
  logic [63:0] r_hold;
  logic [7:0]  r_left;       // data words still to accept after the held first word
  logic [3:0]  r_last_mask;

  logic        w_accept, w_first_acc, w_fits, w_admit, w_drop, w_sync_err, w_last;
  logic [7:0]  w_len;
  logic [10:0] w_need;
  logic [63:0] w_hdr;
  state_t      w_done_state;

  always_comb begin
    w_len = cfg_frame_words;
    if (cfg_frame_words == 8'd0)                      w_len = 8'd1;
    else if (cfg_frame_words > 8'(MAX_FRAME_WORDS))   w_len = 8'(MAX_FRAME_WORDS);
  end

  // Compare occupancy + packet + margin against depth so nothing can underflow.
  assign w_need      = 11'(fifo_count) + 11'(w_len) + 11'(1 + ADMIT_MARGIN);
  assign w_fits      = (w_need <= 11'(FIFO_DEPTH));
  assign w_accept    = src_valid && src_ready;
  assign w_first_acc = (r_state == S_HUNT) && enable && w_accept && src_first;
  assign w_admit     = w_first_acc && w_fits;
  assign w_drop      = w_first_acc && !w_fits;
  assign w_sync_err  = (r_state == S_HUNT) && enable && w_accept && !src_first;
  assign w_last      = (r_left == 8'd1);
  assign w_done_state = enable ? S_HUNT : S_IDLE;

  assign src_ready = (r_state == S_HUNT) || (r_state == S_DATA) || (r_state == S_DROP);
  assign busy      = (r_state != S_IDLE);

  always_comb begin
    w_hdr = '0;
    w_hdr[HDR_MAGIC_LSB +: 16] = HEADER_MAGIC;
    w_hdr[HDR_FC_LSB    +: 16] = frame_count[15:0];
    w_hdr[HDR_TS_LSB    +: 32] = r_ts;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (enable) w_next = S_HUNT;
      S_HUNT: begin
        if (!enable)     w_next = S_IDLE;
        else if (w_admit) w_next = S_HEADER;
        else if (w_drop)  w_next = (w_len == 8'd1) ? S_HUNT : S_DROP;
      end
      S_HEADER: w_next = (r_left == 8'd0) ? w_done_state : S_DATA;
      S_DATA,
      S_DROP:   if (w_accept && w_last) w_next = w_done_state;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state              <= S_IDLE;
      r_ts                 <= '0;
      r_hold               <= '0;
      r_left               <= '0;
      r_last_mask          <= '0;
      fifo_write_en        <= 1'b0;
      fifo_write_data      <= '0;
      fifo_channel_mask    <= '0;
      fifo_packet_end_flag <= 1'b0;
      frame_count          <= '0;
      overflow_sticky      <= 1'b0;
    end else begin
      r_state              <= w_next;
      r_ts                 <= r_ts + 32'd1;
      fifo_write_en        <= 1'b0;
      fifo_packet_end_flag <= 1'b0;
      if (fifo_write_en && fifo_full) overflow_sticky <= 1'b1;
      case (r_state)
        S_HUNT: begin
          if (w_admit) begin
            // Header is registered on the admission edge so the held first
            // word follows it back-to-back; it carries the pre-increment count.
            r_hold            <= src_data;
            r_left            <= w_len - 8'd1;
            r_last_mask       <= cfg_last_mask;
            frame_count       <= frame_count + 32'd1;
            fifo_write_en     <= 1'b1;
            fifo_write_data   <= w_hdr;
            fifo_channel_mask <= 4'hF;
          end else if (w_drop) begin
            r_left <= w_len - 8'd1;
          end
        end
        S_HEADER: begin
          fifo_write_en        <= 1'b1;
          fifo_write_data      <= r_hold;
          fifo_channel_mask    <= (r_left == 8'd0) ? r_last_mask : 4'hF;
          fifo_packet_end_flag <= (r_left == 8'd0);
        end
        S_DATA: begin
          if (w_accept) begin
            fifo_write_en        <= 1'b1;
            fifo_write_data      <= src_data;
            fifo_channel_mask    <= w_last ? r_last_mask : 4'hF;
            fifo_packet_end_flag <= w_last;
            r_left               <= r_left - 8'd1;
          end
        end
        S_DROP: if (w_accept) r_left <= r_left - 8'd1;
        default: ;
      endcase
    end
  end

  sat_counter #(.WIDTH(16)) u_drop_cnt (
    .clk(clk), .rstn(rstn), .inc(w_drop), .count(drop_count)
  );

  sat_counter #(.WIDTH(16)) u_sync_cnt (
    .clk(clk), .rstn(rstn), .inc(w_sync_err), .count(sync_err_count)
  );

endmodule

// File: tb/tb_frame_fifo_sequencer.sv
module tb_frame_fifo_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  cfg_frame_words = 8'd4;
  logic [3:0]  cfg_last_mask = 4'h3;
  logic        src_valid = 1'b0, src_first = 1'b0;
  logic [63:0] src_data = '0;
  logic        src_ready;
  logic        fifo_full = 1'b0;
  logic [8:0]  fifo_count = '0;
  logic        fifo_write_en, fifo_packet_end_flag, overflow_sticky, busy;
  logic [63:0] fifo_write_data;
  logic [3:0]  fifo_channel_mask;
  logic [31:0] frame_count;
  logic [15:0] drop_count, sync_err_count;

  frame_fifo_sequencer dut (
    .clk(clk), .rstn(rstn), .enable(enable),
    .cfg_frame_words(cfg_frame_words), .cfg_last_mask(cfg_last_mask),
    .src_valid(src_valid), .src_first(src_first), .src_data(src_data),
    .src_ready(src_ready), .fifo_full(fifo_full), .fifo_count(fifo_count),
    .fifo_write_en(fifo_write_en), .fifo_write_data(fifo_write_data),
    .fifo_channel_mask(fifo_channel_mask), .fifo_packet_end_flag(fifo_packet_end_flag),
    .frame_count(frame_count), .drop_count(drop_count), .sync_err_count(sync_err_count),
    .overflow_sticky(overflow_sticky), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference cycle counter, same reset/advance rule as the timestamp.
  logic [31:0] tb_ts = '0;
  always @(posedge clk or negedge rstn)
    if (!rstn) tb_ts <= '0; else tb_ts <= tb_ts + 32'd1;

  // Write monitor: running count plus attributes of the latest write.
  int       wr_cnt = 0;
  logic [3:0] last_m = '0;
  logic     last_pe = 1'b0;
  always @(negedge clk)
    if (fifo_write_en) begin
      wr_cnt  = wr_cnt + 1;
      last_m  = fifo_channel_mask;
      last_pe = fifo_packet_end_flag;
    end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, leave time to settle.
  task automatic cyc(input logic en, input logic v, input logic f, input logic [63:0] d);
    @(posedge clk); #1;
    enable = en; src_valid = v; src_first = f; src_data = d;
    #3;
  endtask

  task automatic send_word(input logic en, input logic f, input logic [63:0] d);
    bit got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      cyc(en, 1'b1, f, d);
      if (src_ready) got = 1;
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_frame(input logic en_first, input logic en_rest, input int n,
                            input logic [63:0] base);
    send_word(en_first, 1'b1, base);
    for (int i = 1; i < n; i++) send_word(en_rest, 1'b0, base + 64'(i));
  endtask

  task automatic drain(input logic en);
    for (int i = 0; i < 4; i++) cyc(en, 1'b0, 1'b0, 64'd0);
  endtask

  typedef struct {
    logic        en, v, f;
    logic [63:0] d;
    logic        rdy, we, hdr;
    logic [63:0] ed;     // expected data; for header rows [15:0] = expected frame field
    logic [3:0]  em;
    logic        epe;
  } vec_t;

  vec_t vt [8];
  int   base;

  initial begin
    logic [63:0] d0, d1, d2, d3, exp_d;
    d0 = 64'hD000_0000_0000_0000; d1 = d0 + 64'd1; d2 = d0 + 64'd2; d3 = d0 + 64'd3;
    // en v f d | rdy we hdr ed em pe
    vt[0] = '{1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 4'h0, 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b1, d0,    1'b1, 1'b0, 1'b0, 64'd0, 4'h0, 1'b0};
    vt[2] = '{1'b1, 1'b1, 1'b0, d1,    1'b0, 1'b1, 1'b1, 64'd0, 4'hF, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b0, d1,    1'b1, 1'b1, 1'b0, d0,    4'hF, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1'b0, d2,    1'b1, 1'b1, 1'b0, d1,    4'hF, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b0, d3,    1'b1, 1'b1, 1'b0, d2,    4'hF, 1'b0};
    vt[6] = '{1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0, d3,    4'h3, 1'b1};
    vt[7] = '{1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 4'h0, 1'b0};

    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst.write_en", 64'(fifo_write_en), 64'd0);
    chk("rst.frame_count", 64'(frame_count), 64'd0);
    chk("rst.drop_count", 64'(drop_count), 64'd0);
    chk("rst.sync_err", 64'(sync_err_count), 64'd0);
    chk("rst.busy_ready", {62'd0, busy, src_ready}, 64'd0);
    chk("rst.data", fifo_write_data, 64'd0);
    rstn = 1'b1;

    // Nominal 4-word frame, cycle by cycle.
    for (int i = 0; i < 8; i++) begin
      cyc(vt[i].en, vt[i].v, vt[i].f, vt[i].d);
      chk($sformatf("vec%0d.ready", i), 64'(src_ready), 64'(vt[i].rdy));
      chk($sformatf("vec%0d.we", i), 64'(fifo_write_en), 64'(vt[i].we));
      if (vt[i].we) begin
        exp_d = vt[i].hdr ? {16'hA5C3, vt[i].ed[15:0], tb_ts - 32'd1} : vt[i].ed;
        chk($sformatf("vec%0d.data", i), fifo_write_data, exp_d);
        chk($sformatf("vec%0d.mask_pe", i), {59'd0, fifo_channel_mask, fifo_packet_end_flag},
            {59'd0, vt[i].em, vt[i].epe});
      end
    end
    chk("nom.frame_count", 64'(frame_count), 64'd1);
    chk("nom.overflow", 64'(overflow_sticky), 64'd0);

    // Admission boundary: free 7 admits, free 6 drops, then hunt resumes.
    fifo_count = 9'd249; base = wr_cnt;
    send_frame(1'b1, 1'b1, 4, 64'h100); drain(1'b1);
    chk("adm249.writes", 64'(wr_cnt - base), 64'd5);
    chk("adm249.frame_count", 64'(frame_count), 64'd2);
    fifo_count = 9'd250; base = wr_cnt;
    send_frame(1'b1, 1'b1, 4, 64'h200); drain(1'b1);
    chk("drop250.writes", 64'(wr_cnt - base), 64'd0);
    chk("drop250.drop_count", 64'(drop_count), 64'd1);
    chk("drop250.frame_count", 64'(frame_count), 64'd2);
    fifo_count = 9'd0; base = wr_cnt;
    send_frame(1'b1, 1'b1, 4, 64'h300); drain(1'b1);
    chk("after_drop.writes", 64'(wr_cnt - base), 64'd5);
    chk("after_drop.frame_count", 64'(frame_count), 64'd3);

    // Sync hunt from IDLE; the following frame is written while fifo_full is high.
    cyc(1'b0, 1'b0, 1'b0, 64'd0); cyc(1'b0, 1'b0, 1'b0, 64'd0);
    chk("idle.busy_ready", {62'd0, busy, src_ready}, 64'd0);
    base = wr_cnt;
    for (int i = 0; i < 3; i++) send_word(1'b1, 1'b0, 64'h400 + 64'(i));
    drain(1'b1);
    chk("hunt.sync_err", 64'(sync_err_count), 64'd3);
    chk("hunt.writes", 64'(wr_cnt - base), 64'd0);
    fifo_full = 1'b1; base = wr_cnt;
    send_frame(1'b1, 1'b1, 4, 64'h500); drain(1'b1);
    fifo_full = 1'b0;
    chk("hunt_frame.writes", 64'(wr_cnt - base), 64'd5);
    chk("hunt_frame.last_pe", 64'(last_pe), 64'd1);
    chk("overflow.sticky", 64'(overflow_sticky), 64'd1);

    // enable dropped at word 2: frame completes, then IDLE.
    base = wr_cnt;
    send_frame(1'b1, 1'b0, 4, 64'h600); drain(1'b0);
    chk("en_low.writes", 64'(wr_cnt - base), 64'd5);
    chk("en_low.last_mask", 64'(last_m), 64'h3);
    chk("en_low.busy_ready", {62'd0, busy, src_ready}, 64'd0);
    chk("en_low.frame_count", 64'(frame_count), 64'd5);

    // cfg_frame_words = 0 behaves as a 1-word frame.
    cfg_frame_words = 8'd0; cfg_last_mask = 4'h5; base = wr_cnt;
    send_frame(1'b1, 1'b1, 1, 64'h700); drain(1'b1);
    chk("len0.writes", 64'(wr_cnt - base), 64'd2);
    chk("len0.last_mask_pe", {59'd0, last_m, last_pe}, {59'd0, 4'h5, 1'b1});

    // Async reset in the middle of DATA.
    cfg_frame_words = 8'd4; cfg_last_mask = 4'h3;
    send_word(1'b1, 1'b1, 64'h800);
    send_word(1'b1, 1'b0, 64'h801);
    @(posedge clk); #2 rstn = 1'b0; #1;
    chk("arst.write_en", 64'(fifo_write_en), 64'd0);
    chk("arst.counts", {frame_count, drop_count, sync_err_count}, 64'd0);
    chk("arst.busy_ready_ovf", {61'd0, busy, src_ready, overflow_sticky}, 64'd0);
    #3 rstn = 1'b1;
    base = wr_cnt;
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 64'd0);
    chk("post_rst.no_writes", 64'(wr_cnt - base), 64'd0);
    send_frame(1'b1, 1'b1, 4, 64'h900); drain(1'b1);
    chk("post_rst.writes", 64'(wr_cnt - base), 64'd5);
    chk("post_rst.frame_count", 64'(frame_count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_fifo_sequencer.md
Name: frame_fifo_sequencer

Overview:
Sequences 64-bit sample words from the acquisition front end into the FIFO/BRAM packer input (fifo_write_* / fifo_full / fifo_count). Frames each acquisition as one header word plus cfg_frame_words data words, tagging channel masks and the packet-end flag. Admits a frame only when the packer FIFO can hold all of it; otherwise drops the whole frame and counts the drop. PS sees only whole packets in BRAM.

Parameters:
FIFO_DEPTH, 256, packer FIFO depth in 64-bit entries; must match the packer instance.
MAX_FRAME_WORDS, 255, largest legal cfg_frame_words.
ADMIT_MARGIN, 2, extra free entries required at admission; covers packer input-register and count lag.
HEADER_MAGIC, 16'hA5C3, header bits [63:48].

Ports:
clk  in  1  system clock
rstn  in  1  reset; asynchronous, active-low
enable  in  1  PS run control
cfg_frame_words  in  8  data words per frame; 0 treated as 1; sampled at admission
cfg_last_mask  in  4  channel mask for the last data word of a frame; sampled at admission
src_valid  in  1  source word valid
src_first  in  1  source word is the first of a frame
src_data  in  64  source sample word
src_ready  out  1  source handshake; word transfers when src_valid && src_ready
fifo_full  in  1  packer FIFO full
fifo_count  in  9  packer FIFO occupancy
fifo_write_en  out  1  packer write strobe
fifo_write_data  out  64  packer write data
fifo_channel_mask  out  4  valid 16-bit segments of this word
fifo_packet_end_flag  out  1  last word of a packet
frame_count  out  32  frames admitted since reset
drop_count  out  16  frames dropped, saturating
sync_err_count  out  16  words discarded while hunting for src_first, saturating
overflow_sticky  out  1  set if a write is issued while fifo_full=1
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, counters 0, timestamp 0.
- timestamp: free-running 32-bit cycle counter; wraps.
- All fifo_* outputs are registered. A source word accepted in cycle t appears on fifo_write_* in cycle t+1. fifo_write_en is high for exactly one cycle per word.
- IDLE: src_ready=0. enable=1 -> HUNT.
- HUNT: src_ready=1.
  - enable=0 -> IDLE.
  - Accepted word with src_first=0 is discarded; sync_err_count +1.
  - Accepted word with src_first=1: evaluate admission, free = FIFO_DEPTH - fifo_count. Admit if free >= frame_words + 1 + ADMIT_MARGIN.
  - Admit: latch cfg values, frame_count +1, capture timestamp, hold the first word, go HEADER.
  - Reject: drop_count +1, go DROP; the first word counts toward the frame length.
- HEADER: src_ready=0. Write {HEADER_MAGIC, frame_count[15:0], timestamp} with mask 4'hF and packet_end 0. Next: DATA, emitting the held first word in the following cycle.
- DATA: src_ready=1 after the held word is written.
  - Each data word is written with mask 4'hF, except the last, which uses the latched cfg_last_mask with packet_end=1.
  - A 1-word frame writes the held word as last.
  - After the last word: HUNT if enable=1, else IDLE.
  - src_first=1 mid-frame is ignored; the word is treated as data.
- DROP: src_ready=1. Consume the remaining frame_words-1 words with no writes, then HUNT/IDLE as for DATA.
- enable deasserted mid-frame: the current frame (DATA or DROP) completes first. Mid-frame cfg changes have no effect.
- Writes are never suppressed by fifo_full. Any write with fifo_full=1 sets overflow_sticky, which clears only on reset.
- Counters: frame_count wraps; drop_count and sync_err_count saturate at 16'hFFFF.
- Frame word counter is 8 bits and counts down from the latched length.

Decomposition:
- Package frame_seq_pkg: state enum (IDLE, HUNT, HEADER, DATA, DROP), HEADER_MAGIC, header field offsets.
- One sub-module, sat_counter (WIDTH param, inc, count out). Used for drop_count and sync_err_count.

Test Plan:
- Nominal 4-word frame (cfg_frame_words=4, cfg_last_mask=4'h3, fifo_count=0, enable=1) -> 5 consecutive writes: header with [63:48]=A5C3 and [47:32]=0000, then data words; last word has mask 3 and packet_end=1; frame_count=1.
- Admission boundary (FIFO_DEPTH=256, frame_words=4) -> fifo_count=249 (free 7) admits; fifo_count=250 (free 6) drops the frame with zero writes, drop_count=1, and the next src_first is hunted.
- Sync hunt: 3 words with src_first=0 after enable -> sync_err_count=3, no writes; the subsequent src_first frame is emitted normally.
- enable low during word 2 of a 4-word frame -> all 4 data words written, then IDLE with busy=0 and src_ready=0.
- cfg_frame_words=0 -> header plus 1 data word carrying packet_end=1.
- Async rstn pulse mid-DATA -> outputs and counters 0 immediately; after release, no write until a new admitted frame.
